// File: rtl/fpnew_rob_pkg.sv
// Shared types and helpers for the FPU in-order completion buffer.
// status_t mirrors the IEEE exception flag layout {NV, DZ, OF, UF, NX}.
package fpnew_rob_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  function automatic int unsigned rob_id_width(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

endpackage

// File: rtl/fpnew_rob_checker.sv
// Simulation-only checks on writeback legality; carries no logic of its own.
module fpnew_rob_checker #(
  parameter int unsigned NumChannels = 5,
  parameter int unsigned Depth       = 8
) (
  input logic                   clk_i,
  input logic                   rst_i,
  input logic [Depth-1:0]       collision_i,
  input logic [NumChannels-1:0] dropped_i
);

  a_wb_no_collision: assert property (@(posedge clk_i) disable iff (rst_i) collision_i == '0)
    else $warning("fpnew_rob: two channels wrote the same slot, lowest channel kept");

  a_wb_target_open: assert property (@(posedge clk_i) disable iff (rst_i) dropped_i == '0)
    else $warning("fpnew_rob: writeback to unallocated or completed slot dropped");

endmodule

// File: rtl/fpnew_rob_wb_mux.sv
// Writeback merge: per-entry priority select across all opgroup channels.
// The lowest channel index wins when several channels target the same slot.
module fpnew_rob_wb_mux
  import fpnew_rob_pkg::*;
#(
  parameter int unsigned Width       = 64,
  parameter int unsigned NumChannels = 5,
  parameter int unsigned Depth       = 8,
  parameter int unsigned IdWidth     = 3
) (
  input  logic                                flush_i,
  input  logic [Depth-1:0]                    open_i,
  input  logic [NumChannels-1:0]              wb_valid_i,
  input  logic [NumChannels-1:0][IdWidth-1:0] wb_id_i,
  input  logic [NumChannels-1:0][Width-1:0]   wb_result_i,
  input  status_t [NumChannels-1:0]           wb_status_i,
  output logic [Depth-1:0]                    we_o,
  output logic [Depth-1:0][Width-1:0]         result_o,
  output status_t [Depth-1:0]                 status_o,
  output logic [Depth-1:0]                    collision_o,
  output logic [NumChannels-1:0]              dropped_o
);

  // Per-entry select of the first matching channel, plus illegal-target flags.
  always_comb begin
    logic hit;
    we_o        = '0;
    result_o    = '0;
    status_o    = '0;
    collision_o = '0;
    dropped_o   = '0;
    hit         = 1'b0;
    for (int e = 0; e < Depth; e++) begin
      hit = 1'b0;
      for (int c = 0; c < NumChannels; c++) begin
        if (wb_valid_i[c] && (wb_id_i[c] == IdWidth'(e))) begin
          if (!hit) begin
            hit         = 1'b1;
            result_o[e] = wb_result_i[c];
            status_o[e] = wb_status_i[c];
          end else begin
            collision_o[e] = !flush_i;
          end
        end else begin
          hit = hit;
        end
      end
      we_o[e] = hit && open_i[e] && !flush_i;
    end
    for (int c = 0; c < NumChannels; c++) begin
      dropped_o[c] = wb_valid_i[c] && !flush_i && !open_i[wb_id_i[c]];
    end
  end

endmodule

// File: rtl/fpnew_rob.sv
// In-order completion buffer: slots allocated at issue, written back by id
// from any opgroup channel, retired strictly in allocation order.
module fpnew_rob
  import fpnew_rob_pkg::*;
#(
  parameter int unsigned Width       = 64,
  parameter int unsigned NumChannels = 5,
  parameter int unsigned Depth       = 8,
  parameter int unsigned TagWidth    = 8,
  localparam int unsigned IdWidth    = rob_id_width(Depth)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                alloc_valid_i,
  output logic                                alloc_ready_o,
  input  logic [TagWidth-1:0]                 alloc_tag_i,
  output logic [IdWidth-1:0]                  alloc_id_o,
  input  logic [NumChannels-1:0]              wb_valid_i,
  output logic [NumChannels-1:0]              wb_ready_o,
  input  logic [NumChannels-1:0][IdWidth-1:0] wb_id_i,
  input  logic [NumChannels-1:0][Width-1:0]   wb_result_i,
  input  status_t [NumChannels-1:0]           wb_status_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [Width-1:0]                    result_o,
  output status_t                             status_o,
  output logic [TagWidth-1:0]                 tag_o,
  output logic [IdWidth:0]                    count_o,
  output logic                                busy_o
);

  typedef struct packed {
    logic [Width-1:0]    result;
    status_t             status;
    logic [TagWidth-1:0] tag;
  } rob_entry_t;

  typedef logic [IdWidth:0] ptr_t;

  ptr_t                    head_q, head_d, tail_q, tail_d;
  logic [Depth-1:0]        alloc_q, alloc_d, done_q, done_d;
  rob_entry_t [Depth-1:0]  entry_q, entry_d;
  logic [IdWidth-1:0]      head_idx, tail_idx;
  logic                    full, empty, alloc_fire, retire;
  logic [Depth-1:0]        wb_we, wb_collision;
  logic [Depth-1:0][Width-1:0] wb_result;
  status_t [Depth-1:0]     wb_status;
  logic [NumChannels-1:0]  wb_dropped;

  assign head_idx      = head_q[IdWidth-1:0];
  assign tail_idx      = tail_q[IdWidth-1:0];
  // Wrap bits differ with equal indices: the tail has lapped the head.
  assign full          = (head_q[IdWidth] != tail_q[IdWidth]) && (head_idx == tail_idx);
  assign empty         = (head_q == tail_q);
  assign alloc_ready_o = !full && !flush_i;
  assign alloc_id_o    = tail_idx;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign out_valid_o   = !empty && done_q[head_idx] && !flush_i;
  assign retire        = out_valid_o && out_ready_i;
  assign result_o      = entry_q[head_idx].result;
  assign status_o      = entry_q[head_idx].status;
  assign tag_o         = entry_q[head_idx].tag;
  assign count_o       = tail_q - head_q;
  assign busy_o        = (count_o != '0);
  assign wb_ready_o    = '1;

  fpnew_rob_wb_mux #(
    .Width       (Width),
    .NumChannels (NumChannels),
    .Depth       (Depth),
    .IdWidth     (IdWidth)
  ) i_wb_mux (
    .flush_i     (flush_i),
    .open_i      (alloc_q & ~done_q),
    .wb_valid_i  (wb_valid_i),
    .wb_id_i     (wb_id_i),
    .wb_result_i (wb_result_i),
    .wb_status_i (wb_status_i),
    .we_o        (wb_we),
    .result_o    (wb_result),
    .status_o    (wb_status),
    .collision_o (wb_collision),
    .dropped_o   (wb_dropped)
  );

  fpnew_rob_checker #(
    .NumChannels (NumChannels),
    .Depth       (Depth)
  ) i_checker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .collision_i (wb_collision),
    .dropped_i   (wb_dropped)
  );

  // Next-state: flush wins; otherwise retire, writeback and allocate together.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    alloc_d = alloc_q;
    done_d  = done_q;
    entry_d = entry_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      alloc_d = '0;
      done_d  = '0;
    end else begin
      if (retire) begin
        alloc_d[head_idx] = 1'b0;
        done_d[head_idx]  = 1'b0;
        head_d            = head_q + ptr_t'(1);
      end else begin
        head_d = head_q;
      end
      for (int e = 0; e < Depth; e++) begin
        if (wb_we[e]) begin
          done_d[e]         = 1'b1;
          entry_d[e].result = wb_result[e];
          entry_d[e].status = wb_status[e];
        end else begin
          entry_d[e].result = entry_q[e].result;
        end
      end
      // The tail slot is never open, so it cannot collide with a writeback.
      if (alloc_fire) begin
        alloc_d[tail_idx]     = 1'b1;
        done_d[tail_idx]      = 1'b0;
        entry_d[tail_idx].tag = alloc_tag_i;
        tail_d                = tail_q + ptr_t'(1);
      end else begin
        tail_d = tail_q;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      alloc_q <= alloc_d;
      done_q  <= done_d;
    end
  end

  // Payload storage; only read behind the alloc/done bits, so no reset.
  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
  end

endmodule

// File: tb/tb_fpnew_rob.sv
// Scoreboard bench for fpnew_rob at Depth=4, NumChannels=3, TagWidth=8.
module tb_fpnew_rob;

  localparam int W  = 16;
  localparam int NC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_i, flush_i, alloc_valid_i, alloc_ready_o, out_valid_o, out_ready_i, busy_o;
  logic [7:0]           alloc_tag_i, tag_o;
  logic [1:0]           alloc_id_o;
  logic [NC-1:0]        wb_valid_i, wb_ready_o;
  logic [NC-1:0][1:0]   wb_id_i;
  logic [NC-1:0][W-1:0] wb_result_i;
  logic [NC-1:0][4:0]   wb_status_i;
  logic [W-1:0]         result_o;
  logic [4:0]           status_o;
  logic [2:0]           count_o;

  fpnew_rob #(.Width(W), .NumChannels(NC), .Depth(4), .TagWidth(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_tag_i(alloc_tag_i), .alloc_id_o(alloc_id_o),
    .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o), .wb_id_i(wb_id_i),
    .wb_result_i(wb_result_i), .wb_status_i(wb_status_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
    .count_o(count_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [7:0] tag;
    int         id;
  } sb_t;

  sb_t        sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit [3:0]   m_alloc, m_done;
  logic [W-1:0] m_res[4];
  logic [4:0] m_stat[4];
  logic [2:0] m_head, m_tail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_alloc = '0;
    m_done  = '0;
    m_head  = '0;
    m_tail  = '0;
    sb_q.delete();
  endtask

  task automatic set_wb(input int c, input int id, input logic [W-1:0] res, input logic [4:0] st);
    wb_valid_i[c]  = 1'b1;
    wb_id_i[c]     = 2'(id);
    wb_result_i[c] = res;
    wb_status_i[c] = st;
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model, cross the edge.
  task automatic tick();
    logic [2:0] cnt;
    logic       mv;
    bit [3:0]   taken;
    sb_t        e;
    int         id;
    @(negedge clk);
    if (rst_i) begin
      model_clear();
    end else if (flush_i) begin
      check_eq("flush_out_valid", {63'd0, out_valid_o}, 64'd0);
      check_eq("flush_alloc_ready", {63'd0, alloc_ready_o}, 64'd0);
      model_clear();
    end else begin
      cnt = m_tail - m_head;
      mv  = (cnt != 3'd0) && m_done[m_head[1:0]];
      check_eq("count", {61'd0, count_o}, {61'd0, cnt});
      check_eq("busy", {63'd0, busy_o}, {63'd0, cnt != 3'd0});
      check_eq("alloc_ready", {63'd0, alloc_ready_o}, {63'd0, cnt != 3'd4});
      check_eq("alloc_id", {62'd0, alloc_id_o}, {62'd0, m_tail[1:0]});
      check_eq("out_valid", {63'd0, out_valid_o}, {63'd0, mv});
      if (mv) begin
        check_eq("head_result", {48'd0, result_o}, {48'd0, m_res[m_head[1:0]]});
        check_eq("head_status", {59'd0, status_o}, {59'd0, m_stat[m_head[1:0]]});
      end
      taken = '0;
      for (int c = 0; c < NC; c++) begin
        if (wb_valid_i[c]) begin
          id = int'(wb_id_i[c]);
          if (!taken[id]) begin
            taken[id] = 1'b1;
            if (m_alloc[id] && !m_done[id]) begin
              m_done[id] = 1'b1;
              m_res[id]  = wb_result_i[c];
              m_stat[id] = wb_status_i[c];
            end
          end
        end
      end
      if (mv && out_ready_i) begin
        if (sb_q.size() == 0) begin
          check_eq("retire_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("retire_tag", {56'd0, tag_o}, {56'd0, e.tag});
          check_eq("retire_result", {48'd0, result_o}, {48'd0, m_res[e.id]});
        end
        m_alloc[m_head[1:0]] = 1'b0;
        m_done[m_head[1:0]]  = 1'b0;
        m_head               = m_head + 3'd1;
      end
      if (alloc_valid_i && (cnt != 3'd4)) begin
        e.tag = alloc_tag_i;
        e.id  = int'(m_tail[1:0]);
        sb_q.push_back(e);
        m_alloc[m_tail[1:0]] = 1'b1;
        m_done[m_tail[1:0]]  = 1'b0;
        m_tail               = m_tail + 3'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_n(input int n, input logic [7:0] tag0);
    for (int i = 0; i < n; i++) begin
      alloc_valid_i = 1'b1;
      alloc_tag_i   = tag0 + 8'(i);
      tick();
    end
    alloc_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; alloc_valid_i = 1'b0; alloc_tag_i = 8'h00;
    wb_valid_i = '0; wb_id_i = '0; wb_result_i = '0; wb_status_i = '0; out_ready_i = 1'b0;
    model_clear();
    tick(); tick();
    rst_i = 1'b0;

    // In-order retire of out-of-order writebacks.
    out_ready_i = 1'b1;
    alloc_n(3, 8'h10);
    set_wb(2, 2, 16'h2222, 5'b00001); tick(); wb_valid_i = '0;
    set_wb(0, 0, 16'h1000, 5'b00000); tick(); wb_valid_i = '0;
    set_wb(1, 1, 16'h1111, 5'b00100); tick(); wb_valid_i = '0;
    repeat (4) tick();

    // Full buffer, retire with blocked alloc, then wrap.
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    out_ready_i = 1'b0;
    alloc_n(4, 8'h20);
    tick();
    set_wb(0, 0, 16'h2000, 5'b00010); tick(); wb_valid_i = '0;
    out_ready_i = 1'b1; alloc_valid_i = 1'b1; alloc_tag_i = 8'h24;
    tick(); tick();
    alloc_valid_i = 1'b0;
    set_wb(0, 1, 16'h2101, 5'b00000);
    set_wb(1, 2, 16'h2202, 5'b01000);
    set_wb(2, 3, 16'h2303, 5'b00000);
    tick(); wb_valid_i = '0;
    set_wb(1, 0, 16'h2404, 5'b00000); tick(); wb_valid_i = '0;
    repeat (5) tick();

    // Collision on id1 and a stray writeback to unallocated id3.
    out_ready_i = 1'b0;
    alloc_n(2, 8'h30);
    set_wb(0, 1, 16'h000A, 5'b00000);
    set_wb(2, 1, 16'h000B, 5'b11111);
    set_wb(1, 3, 16'h000C, 5'b00000);
    tick(); wb_valid_i = '0;
    tick();
    set_wb(1, 2, 16'h000D, 5'b00000); out_ready_i = 1'b1; tick(); wb_valid_i = '0;
    repeat (3) tick();

    // Flush with a simultaneous alloc and writeback.
    out_ready_i = 1'b0;
    alloc_n(3, 8'h40);
    set_wb(0, 3, 16'h4003, 5'b00000);
    set_wb(1, 0, 16'h4000, 5'b00000);
    tick(); wb_valid_i = '0;
    flush_i = 1'b1; alloc_valid_i = 1'b1; alloc_tag_i = 8'h43;
    set_wb(2, 1, 16'h4001, 5'b00000);
    tick();
    flush_i = 1'b0; alloc_valid_i = 1'b0; wb_valid_i = '0;
    tick();

    // Head held under backpressure with NV set.
    alloc_n(1, 8'h50);
    set_wb(1, 0, 16'h5555, 5'b10000); tick(); wb_valid_i = '0;
    repeat (3) tick();
    check_eq("held_nv", {63'd0, status_o[4]}, 64'd1);
    out_ready_i = 1'b1; tick(); tick();

    // Reset with two entries pending.
    out_ready_i = 1'b0;
    alloc_n(2, 8'h60);
    set_wb(0, 0, 16'h6000, 5'b00000); tick(); wb_valid_i = '0;
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    out_ready_i = 1'b1;
    tick(); tick();
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpnew_rob.md
Name: fpnew_rob

Overview:
- Parametrised in-order completion buffer (reorder buffer) for the FPU top level.
- Generalises the per-opgroup round-robin output arbitration. Results from N operation-group channels with different latencies complete out of order; this block returns them to the requester in issue order.
- The dispatcher allocates a slot at issue and carries the slot id through the opgroup as part of its tag. Opgroups write back by id, and the block retires from the head strictly in order.

Parameters:
- Width, 64, result width in bits
- NumChannels, 5, number of writeback channels (one per opgroup)
- Depth, 8, number of entries; must be a power of two, >= 2
- TagWidth, 8, width of the user tag stored per entry
- IdWidth, $clog2(Depth) (localparam), slot id width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  discard all entries
- alloc_valid_i  in  1  request a slot at issue
- alloc_ready_o  out  1  slot available
- alloc_tag_i  in  TagWidth  user tag for the allocated entry
- alloc_id_o  out  IdWidth  id of the slot granted this cycle
- wb_valid_i  in  NumChannels  per-channel writeback valid
- wb_ready_o  out  NumChannels  per-channel writeback ready
- wb_id_i  in  NumChannels x IdWidth  target slot per channel
- wb_result_i  in  NumChannels x Width  result per channel
- wb_status_i  in  NumChannels x 5  fpnew_pkg::status_t per channel
- out_valid_o  out  1  head entry complete
- out_ready_i  in  1  consumer accepts head
- result_o  out  Width  head result
- status_o  out  5  head status
- tag_o  out  TagWidth  head user tag
- count_o  out  IdWidth+1  allocated entries
- busy_o  out  1  count_o != 0

Behaviour:
- State:
  - head and tail pointers, each IdWidth+1 bits; the MSB is the wrap bit.
  - Per entry: alloc bit, done bit, result, status, tag.
- Full/empty:
  - full = (head[Id] != tail[Id]) && (head[Id-1:0] == tail[Id-1:0]).
  - empty = (head == tail).
- Allocation:
  - alloc_ready_o = !full && !flush_i. It does not depend on out_ready_i, so there is no comb path from the consumer.
  - alloc_id_o = tail[IdWidth-1:0], driven combinationally.
  - On valid && ready at edge N: the entry's alloc bit is set, done is cleared, the tag is stored, and tail increments with wrap.
- Writeback:
  - wb_ready_o = all ones; there is no backpressure.
  - A valid writeback to an entry with alloc=1 && done=0 stores result and status and sets done at the edge.
  - A writeback to an unallocated or already-done entry is dropped; a simulation assertion fires.
  - Same id on two channels in one cycle: the lowest channel index wins; the assertion fires.
  - Writebacks to distinct ids in the same cycle are all accepted.
- Retire:
  - out_valid_o = !empty && done[head]. result_o, status_o and tag_o come combinationally from the head entry's registers.
  - On valid && ready: alloc and done of the head entry are cleared and head increments.
  - Latency: a writeback accepted at edge N appears on the outputs after edge N (next cycle) at the earliest, provided it is at head.
- Simultaneous events:
  - Alloc and retire in the same cycle are legal, including when full (alloc is blocked by the registered full) and when one entry remains.
  - count_o is updated by +1, -1 or 0.
  - A writeback to the head entry in the same cycle as a retire of an older entry cannot occur, since the head is unique.
- Flush:
  - Takes priority over every other event.
  - Alloc and writeback in the flush cycle are ignored.
  - At the next edge: all alloc/done bits cleared, head = tail = 0.
  - out_valid_o is forced low during the flush cycle.
- Reset:
  - Same effect as flush; the result/status/tag arrays need no reset.
  - After reset: alloc_ready_o=1, alloc_id_o=0, out_valid_o=0, result_o/status_o/tag_o don't-care (all-zero preferred), count_o=0, busy_o=0.
  - Reset mid-operation discards all in-flight entries, with no retire.

Decomposition:
- Add to fpnew_pkg:
  - function rob_id_width(depth)
  - a packed rob_entry_t struct {result, status_t, tag}, parametrised through the module's localparam typedef
- Writeback merge (per-entry priority select across channels) is natural as one sub-module: fpnew_rob_wb_mux. It takes the channel vectors and yields per-entry write-enable and data.
- Everything else stays in fpnew_rob.

Test Plan (Depth=4, NumChannels=3, TagWidth=8):
- Reset, then alloc tags 0x10, 0x11, 0x12 -> ids 0, 1, 2. Writebacks in order ch2 id2, ch0 id0, ch1 id1, one per cycle -> outputs retire 0x10, 0x11, 0x12 in order; out_valid_o first high the cycle after id0's writeback.
- Fill 4 entries -> alloc_ready_o=0, count_o=4. Writeback id0 and retire it while alloc_valid_i=1 -> the alloc is granted only in the following cycle, with alloc_id_o=0 (wrap); head wrap bit toggles after 4 retires.
- Same cycle: ch0 and ch2 both write id1 with results 0xA and 0xB -> 0xA stored, assertion reported. A writeback to unallocated id3 -> ignored, count unchanged.
- 3 entries allocated, 2 done, flush_i pulse with a simultaneous alloc and writeback -> next cycle count_o=0, out_valid_o=0, busy_o=0, alloc_id_o=0.
- Hold out_ready_i=0 with the head done and status NV=1 -> out_valid_o, result_o and status_o stay stable across cycles until accepted.
- rst_i asserted mid-stream with 2 entries pending -> next cycle all outputs at reset values; no retire observed.
